// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// One operation is in flight at a time. Its operands are captured at issue,
// and HI/LO are written when the down-counter reaches its terminal count.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_MDOp,
   input  logic [31:0] E_Forward1,
   input  logic [31:0] E_Forward2,
   output logic        E_MD_start,
   output logic        E_MD_busy,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [CW-1:0] cnt;
   logic [2:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;

   logic [63:0] prod_u;
   logic [63:0] prod_s;
   logic [31:0] b_safe;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_b_safe;
   logic [31:0] quo_m;
   logic [31:0] rem_m;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_valid;

   assign E_MD_busy  = (cnt != '0);
   assign E_MD_start = (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU) && !E_MD_busy;

   // Products: sign-extending to 64 bits makes the low 64 bits of the
   // unsigned product equal to the signed product.
   assign prod_u = {32'b0, a_q} * {32'b0, b_q};
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

   // Signed divide through magnitudes; this keeps 0x80000000 / -1 a plain wrap.
   // A zero divisor is replaced by 1 only to keep the datapath defined;
   // that result is never written back.
   assign b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
   assign mag_a      = a_q[31] ? (32'd0 - a_q) : a_q;
   assign mag_b      = b_q[31] ? (32'd0 - b_q) : b_q;
   assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign quo_m      = mag_a / mag_b_safe;
   assign rem_m      = mag_a % mag_b_safe;

   // Select the completion result for the latched op.
   always_comb begin
      res_hi    = E_HI;
      res_lo    = E_LO;
      res_valid = 1'b0;
      case (op_q)
         OP_MULT: begin
            {res_hi, res_lo} = prod_s;
            res_valid        = 1'b1;
         end
         OP_MULTU: begin
            {res_hi, res_lo} = prod_u;
            res_valid        = 1'b1;
         end
         OP_DIV: begin
            res_lo    = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_m) : quo_m;
            res_hi    = a_q[31] ? (32'd0 - rem_m) : rem_m;
            res_valid = (b_q != 32'd0);
         end
         OP_DIVU: begin
            res_lo    = a_q / b_safe;
            res_hi    = a_q % b_safe;
            res_valid = (b_q != 32'd0);
         end
         default: ;
      endcase
   end

   // Issue, countdown, completion write and idle mthi/mtlo writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         op_q <= 3'd0;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         E_HI <= 32'd0;
         E_LO <= 32'd0;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_ONE;
         if (cnt == CNT_ONE && res_valid) begin
            E_HI <= res_hi;
            E_LO <= res_lo;
         end
      end else begin
         case (E_MDOp)
            OP_MULT, OP_MULTU: begin
               op_q <= E_MDOp;
               a_q  <= E_Forward1;
               b_q  <= E_Forward2;
               cnt  <= MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
               op_q <= E_MDOp;
               a_q  <= E_Forward1;
               b_q  <= E_Forward2;
               cnt  <= DIV_LOAD;
            end
            OP_MTHI: E_HI <= E_Forward1;
            OP_MTLO: E_LO <= E_Forward1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit. It keeps a reference model of HI/LO and a
// scoreboard queue of expected completion results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  E_MDOp;
   logic [31:0] E_Forward1;
   logic [31:0] E_Forward2;
   logic        E_MD_start;
   logic        E_MD_busy;
   logic [31:0] E_HI;
   logic [31:0] E_LO;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] sb_q[$];

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .E_MDOp     (E_MDOp),
      .E_Forward1 (E_Forward1),
      .E_Forward2 (E_Forward2),
      .E_MD_start (E_MD_start),
      .E_MD_busy  (E_MD_busy),
      .E_HI       (E_HI),
      .E_LO       (E_LO)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ph,
                                         input logic [31:0] pl);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd1: return sa * sb;
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return {ph, pl};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {ph, pl};
            return {a % b, a / b};
         end
         default: return {ph, pl};
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      E_MDOp = op; E_Forward1 = a; E_Forward2 = b;
      #1;
      tests++;
      if (E_MD_start !== 1'b1) begin
         fails++;
         $display("FAIL issue_start op=%0d: got %b want 1", op, E_MD_start);
      end
      sb_q.push_back(model(op, a, b, m_hi, m_lo));
      @(posedge clk); #1;
      E_MDOp = 3'd0; E_Forward1 = $urandom; E_Forward2 = $urandom;
   endtask

   task automatic wait_done(input int exp_cycles, input string name);
      int n = 0;
      logic [63:0] e;
      while (E_MD_busy === 1'b1 && n < 200) begin
         tests++;
         if (E_HI !== m_hi || E_LO !== m_lo) begin
            fails++;
            $display("FAIL %s_hold: HI/LO=%h/%h want %h/%h", name, E_HI, E_LO, m_hi, m_lo);
         end
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n !== exp_cycles) begin
         fails++;
         $display("FAIL %s_latency: busy %0d cycles want %0d", name, n, exp_cycles);
      end
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $display("FAIL %s_scoreboard: queue empty want 1 entry", name);
      end else begin
         e = sb_q.pop_front();
         if ({E_HI, E_LO} !== e) begin
            fails++;
            $display("FAIL %s_result: HI/LO=%h/%h want %h/%h", name, E_HI, E_LO, e[63:32], e[31:0]);
         end
         m_hi = e[63:32];
         m_lo = e[31:0];
      end
   endtask

   task automatic write_hilo(input logic [2:0] op, input logic [31:0] val);
      @(negedge clk);
      E_MDOp = op; E_Forward1 = val;
      #1;
      tests++;
      if (E_MD_start !== 1'b0) begin
         fails++;
         $display("FAIL mthilo_start: got %b want 0", E_MD_start);
      end
      @(posedge clk); #1;
      E_MDOp = 3'd0;
      if (op == 3'd5) m_hi = val; else m_lo = val;
      tests++;
      if (E_MD_busy !== 1'b0 || E_HI !== m_hi || E_LO !== m_lo) begin
         fails++;
         $display("FAIL mthilo_write: busy=%b HI/LO=%h/%h want 0 %h/%h", E_MD_busy, E_HI, E_LO, m_hi, m_lo);
      end
   endtask

   task automatic check_const(input string name, input logic [31:0] hi, input logic [31:0] lo);
      tests++;
      if (E_HI !== hi || E_LO !== lo) begin
         fails++;
         $display("FAIL %s_const: HI/LO=%h/%h want %h/%h", name, E_HI, E_LO, hi, lo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; E_MDOp = 3'd0; E_Forward1 = 32'd0; E_Forward2 = 32'd0;
      #1;
      tests++;
      if (E_MD_busy !== 1'b0 || E_MD_start !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
         fails++;
         $display("FAIL reset_state: busy=%b start=%b HI/LO=%h/%h want 0 0 0/0",
                  E_MD_busy, E_MD_start, E_HI, E_LO);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult();
      issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
      wait_done(5, "mult");
      check_const("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
   endtask

   task automatic test_multu();
      issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
      wait_done(5, "multu");
      check_const("multu", 32'h00000001, 32'hFFFFFFFE);
   endtask

   task automatic test_div();
      issue(3'd3, 32'hFFFFFFF9, 32'h00000002);
      wait_done(10, "div");
      check_const("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
   endtask

   task automatic test_div_zero();
      write_hilo(3'd5, 32'h11111111);
      write_hilo(3'd6, 32'h22222222);
      issue(3'd4, 32'd7, 32'd0);
      wait_done(10, "divu_zero");
      check_const("divu_zero", 32'h11111111, 32'h22222222);
   endtask

   task automatic test_div_overflow();
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_done(10, "div_ovf");
      check_const("div_ovf", 32'h00000000, 32'h80000000);
   endtask

   task automatic test_busy_ignore();
      issue(3'd1, 32'h00001234, 32'h00000010);
      @(negedge clk);
      E_MDOp = 3'd6; E_Forward1 = 32'hABCD0000;
      #1;
      tests++;
      if (E_MD_start !== 1'b0) begin
         fails++;
         $display("FAIL busy_start_mtlo: got %b want 0", E_MD_start);
      end
      @(posedge clk); #1;
      E_MDOp = 3'd3; E_Forward1 = 32'd99; E_Forward2 = 32'd3;
      #1;
      tests++;
      if (E_MD_start !== 1'b0) begin
         fails++;
         $display("FAIL busy_start_div: got %b want 0", E_MD_start);
      end
      @(posedge clk); #1;
      E_MDOp = 3'd0;
      wait_done(3, "busy_ignore");
      check_const("busy_ignore", 32'h00000000, 32'h00012340);
      write_hilo(3'd5, 32'h00000005);
      check_const("mthi_idle", 32'h00000005, 32'h00012340);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 20)));
         issue(op, a, b);
         wait_done((op <= 3'd2) ? 5 : 10, "b2b");
      end
      @(negedge clk);
      E_MDOp = 3'd7; E_Forward1 = 32'hFFFF0000;
      #1;
      tests++;
      if (E_MD_start !== 1'b0) begin
         fails++;
         $display("FAIL op7_start: got %b want 0", E_MD_start);
      end
      @(posedge clk); #1;
      E_MDOp = 3'd0;
      tests++;
      if (E_MD_busy !== 1'b0 || E_HI !== m_hi || E_LO !== m_lo) begin
         fails++;
         $display("FAIL op7_idle: busy=%b HI/LO=%h/%h want 0 %h/%h", E_MD_busy, E_HI, E_LO, m_hi, m_lo);
      end
   endtask

   task automatic test_reset_mid();
      write_hilo(3'd5, 32'h0000DEAD);
      write_hilo(3'd6, 32'h0000BEEF);
      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      tests++;
      if (E_MD_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
         fails++;
         $display("FAIL reset_mid_async: busy=%b HI/LO=%h/%h want 0 0/0", E_MD_busy, E_HI, E_LO);
      end
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         tests++;
         if (E_MD_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_hold: cycle %0d busy=%b HI/LO=%h/%h want 0 0/0",
                     i, E_MD_busy, E_HI, E_LO);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      E_MDOp = 3'd2; E_Forward1 = 32'd3; E_Forward2 = 32'd4;
      sb_q.push_back(model(3'd2, 32'd3, 32'd4, m_hi, m_lo));
      @(posedge clk); #1;
      E_MDOp = 3'd0;
      tests++;
      if (E_MD_busy !== 1'b1) begin
         fails++;
         $display("FAIL first_edge_issue: busy=%b want 1", E_MD_busy);
      end
      wait_done(5, "post_reset");
      check_const("post_reset", 32'h00000000, 32'h0000000C);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_div_overflow();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
